// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared loader types, widths and address helper
// Purpose: state encoding, stream-header width and word/bus widths used by the
//          program loader, its byte assembler and its bus interface.
// Ports:   none (package).
package prog_loader_pkg;

  localparam int HDR_W  = 16;  // stream header (word count) width
  localparam int WORD_W = 32;  // instruction word width
  localparam int ADDR_W = 64;  // instruction-memory byte address width

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } loader_state_t;

  // Word index -> byte address (index x 4).
  function automatic logic [ADDR_W-1:0] word_byte_addr(input logic [HDR_W-1:0] idx);
    return {{(ADDR_W-HDR_W-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and instruction-memory write bus
// Purpose: groups the program byte stream and the instruction-memory port.
// Ports:   s_valid/s_data/s_ready  byte stream (transfer when valid & ready)
//          addr_ext/wen_ext/ren_ext/wdata_ext  instruction-memory port
//          modport slave  = loader side, modport master = environment side.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] addr_ext;
  logic              wen_ext;
  logic              ren_ext;
  logic [WORD_W-1:0] wdata_ext;

  modport slave (
    input  s_valid, s_data,
    output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
  );

endinterface

// File: rtl/prog_loader_byte_assembler.sv
// rtl/prog_loader_byte_assembler.sv - little-endian byte-to-word assembler
// Purpose: places accepted bytes into lanes 0..3 of a 32-bit word.
// Ports:   clk, arst     clock, async active-high reset
//          en, byte_in   accept one byte into the current lane
//          word_next     word including the byte being accepted this cycle
//          lane          current byte lane (0..3)
//          done          high while the fourth byte of a word is accepted
module prog_loader_byte_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_next,
  output logic [1:0]        lane,
  output logic              done
);

  logic [WORD_W-1:0] word_q;

  always_comb begin
    word_next = word_q;
    case (lane)
      2'd0:    word_next[7:0]   = byte_in;
      2'd1:    word_next[15:8]  = byte_in;
      2'd2:    word_next[23:16] = byte_in;
      default: word_next[31:24] = byte_in;
    endcase
  end

  assign done = en && (lane == 2'd3);

  // The 2-bit lane counter wraps 3->0 on the fourth byte by itself.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      word_q <= '0;
      lane   <= '0;
    end else if (en) begin
      word_q <= word_next;
      lane   <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a length-prefixed program into instruction memory
// Purpose: parses a 2-byte LE word count N followed by 4*N LE bytes, writes each
//          word to instruction memory, then enables the core.
// Ports:   clk, arst      clock, async active-high reset
//          bus (slave)    byte stream in, instruction-memory write port out
//          cpu_enable     core enable, high only after a complete load
//          busy           load in progress
//          err            sticky error (N > MAX_WORDS)
//          words_loaded   words written so far
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MAX_WORDS = 512
) (
  input  logic             clk,
  input  logic             arst,
  prog_loader_if.slave     bus,
  output logic             cpu_enable,
  output logic             busy,
  output logic             err,
  output logic [HDR_W-1:0] words_loaded
);

  localparam logic [HDR_W:0] MAX_LIM = MAX_WORDS[HDR_W:0];

  loader_state_t     state, state_next;
  logic [HDR_W-1:0]  n_words;
  logic [HDR_W-1:0]  words_inc;
  logic [HDR_W-1:0]  hdr_full;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              accepting;
  logic              xfer;
  logic              asm_en;
  logic              asm_done;
  logic [1:0]        asm_lane;
  logic [WORD_W-1:0] asm_word;

  assign accepting = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign xfer      = bus.s_valid && accepting;
  assign asm_en    = xfer && (state == DATA);
  assign words_inc = words_loaded + 16'd1;
  assign hdr_full  = {bus.s_data, n_words[7:0]};

  prog_loader_byte_assembler u_asm (
    .clk       (clk),
    .arst      (arst),
    .en        (asm_en),
    .byte_in   (bus.s_data),
    .word_next (asm_word),
    .lane      (asm_lane),
    .done      (asm_done)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= LEN_LO;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LEN_LO: if (xfer) state_next = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (hdr_full == '0)                   state_next = RUN;
          else if ({1'b0, hdr_full} > MAX_LIM)  state_next = ERROR;
          else                                  state_next = DATA;
        end
      end
      DATA:   if (asm_done) state_next = WRITE;
      WRITE:  state_next = (words_inc == n_words) ? RUN : DATA;
      RUN:    state_next = RUN;
      ERROR:  state_next = ERROR;
      default: state_next = ERROR;
    endcase
  end

  // Address and data are captured with the last byte so they are valid
  // during WRITE and keep the last written values afterwards.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      n_words      <= '0;
      words_loaded <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      if (xfer && (state == LEN_LO)) n_words[7:0]  <= bus.s_data;
      if (xfer && (state == LEN_HI)) n_words[15:8] <= bus.s_data;
      if (asm_done) begin
        addr_q  <= word_byte_addr(words_loaded);
        wdata_q <= asm_word;
      end
      if (state == WRITE) words_loaded <= words_inc;
    end
  end

  assign bus.s_ready   = accepting;
  assign bus.wen_ext   = (state == WRITE);
  assign bus.ren_ext   = 1'b0;
  assign bus.addr_ext  = addr_q;
  assign bus.wdata_ext = wdata_q;

  // Gated by arst directly so the core stops the instant reset asserts.
  assign cpu_enable = (state == RUN) && !arst;
  assign busy       = (state == LEN_HI) || (state == DATA) || (state == WRITE);
  assign err        = (state == ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard testbench for prog_loader
module tb_prog_loader;
  import prog_loader_pkg::*;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        cpu_enable, busy, err;
  logic [15:0] words_loaded;

  wr_t exp_q[$];
  bq_t stim;
  int  errors = 0;
  int  checks = 0;
  int  wen_cnt = 0;
  int  wen_base;

  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader #(.MAX_WORDS(512)) dut (
    .clk          (clk),
    .arst         (arst),
    .bus          (bus),
    .cpu_enable   (cpu_enable),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.wen_ext === 1'b1) begin
        wen_cnt++;
        check("s_ready_in_write", {63'd0, bus.s_ready}, 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h expected no write",
                   bus.addr_ext, bus.wdata_ext);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.addr_ext, e.addr);
          check("wr_data", {32'd0, bus.wdata_ext}, {32'd0, e.data});
        end
      end
    end
  endtask

  task automatic expect_wr(input logic [63:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Present one byte, wait for acceptance (bounded), then idle 'gap' cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) break;
      waited++;
      if (waited > 20) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: s_ready stayed %b, required 1", bus.s_ready);
        bus.s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic send_stream(input int gap);
    foreach (stim[i]) send_byte(stim[i], gap);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 arst = 1'b1;
    bus.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
  endtask

  task automatic end_test(input string name);
    check({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    fork
      monitor();
    join_none
    #2 arst = 1'b1;
    #10;
    check("rst_s_ready", {63'd0, bus.s_ready}, 64'd1);
    check("rst_wen", {63'd0, bus.wen_ext}, 64'd0);
    check("rst_ren", {63'd0, bus.ren_ext}, 64'd0);
    check("rst_cpu_enable", {63'd0, cpu_enable}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_addr", bus.addr_ext, 64'd0);
    check("rst_wdata", {32'd0, bus.wdata_ext}, 64'd0);
    check("rst_words", {48'd0, words_loaded}, 64'd0);
    @(posedge clk);
    #1 arst = 1'b0;

    // Two-word program, back to back.
    expect_wr(64'd0, 32'h0000_0013);
    expect_wr(64'd4, 32'h0010_0093);
    stim = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_stream(0);
    @(negedge clk);
    check("t1_wen_latency", {63'd0, bus.wen_ext}, 64'd1);
    check("t1_cpu_before", {63'd0, cpu_enable}, 64'd0);
    @(negedge clk);
    check("t1_cpu_enable", {63'd0, cpu_enable}, 64'd1);
    check("t1_words", {48'd0, words_loaded}, 64'd2);
    check("t1_busy_run", {63'd0, busy}, 64'd0);
    check("t1_hold_addr", bus.addr_ext, 64'd4);
    end_test("t1");
    @(posedge clk);
    #1 arst = 1'b1;
    #1;
    check("async_cpu_enable", {63'd0, cpu_enable}, 64'd0);
    check("async_words", {48'd0, words_loaded}, 64'd0);
    @(posedge clk);
    #1 arst = 1'b0;

    // Empty program.
    wen_base = wen_cnt;
    stim = {8'h00, 8'h00};
    send_stream(0);
    @(negedge clk);
    check("t2_cpu_enable", {63'd0, cpu_enable}, 64'd1);
    check("t2_words", {48'd0, words_loaded}, 64'd0);
    check("t2_no_write", 64'(wen_cnt - wen_base), 64'd0);
    do_reset();

    // Oversized header N=513.
    wen_base = wen_cnt;
    stim = {8'h01, 8'h02};
    send_stream(0);
    @(negedge clk);
    check("t3_err", {63'd0, err}, 64'd1);
    check("t3_s_ready", {63'd0, bus.s_ready}, 64'd0);
    check("t3_cpu_enable", {63'd0, cpu_enable}, 64'd0);
    bus.s_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.s_valid = 1'b0;
    @(negedge clk);
    check("t3_err_sticky", {63'd0, err}, 64'd1);
    check("t3_no_write", 64'(wen_cnt - wen_base), 64'd0);
    do_reset();
    check("t3_err_cleared", {63'd0, err}, 64'd0);

    // N=512 is accepted (boundary).
    stim = {8'h00, 8'h02};
    send_stream(0);
    @(negedge clk);
    check("t4_max_err", {63'd0, err}, 64'd0);
    check("t4_max_busy", {63'd0, busy}, 64'd1);
    do_reset();

    // N=1 with idle cycles between bytes, then a busy stream in RUN.
    wen_base = wen_cnt;
    expect_wr(64'd0, 32'h1234_5678);
    stim = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_stream(1);
    @(negedge clk);
    check("t5_cpu_enable", {63'd0, cpu_enable}, 64'd1);
    check("t5_one_write", 64'(wen_cnt - wen_base), 64'd1);
    end_test("t5");
    for (int i = 0; i < 20; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    check("t6_no_write", 64'(wen_cnt - wen_base), 64'd1);
    check("t6_words", {48'd0, words_loaded}, 64'd1);
    check("t6_cpu_enable", {63'd0, cpu_enable}, 64'd1);
    do_reset();

    // Abort mid-word, then a fresh load.
    wen_base = wen_cnt;
    stim = {8'h01, 8'h00, 8'hEF, 8'hBE};
    send_stream(0);
    @(negedge clk);
    check("t7_busy", {63'd0, busy}, 64'd1);
    do_reset();
    check("t7_no_write", 64'(wen_cnt - wen_base), 64'd0);
    check("t7_words", {48'd0, words_loaded}, 64'd0);
    expect_wr(64'd0, 32'hDEAD_BEEF);
    stim = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stream(0);
    repeat (2) @(negedge clk);
    check("t7_cpu_enable", {63'd0, cpu_enable}, 64'd1);
    end_test("t7");
    do_reset();

    // Three words: address stepping.
    expect_wr(64'd0, 32'hAABB_CCDD);
    expect_wr(64'd4, 32'h0000_0001);
    expect_wr(64'd8, 32'hFFFF_FFFF);
    stim = {8'h03, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h01, 8'h00, 8'h00, 8'h00,
            8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_stream(0);
    repeat (2) @(negedge clk);
    check("t8_words", {48'd0, words_loaded}, 64'd3);
    check("t8_cpu_enable", {63'd0, cpu_enable}, 64'd1);
    end_test("t8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
